// File: rtl/fifo_flow_ctrl.sv
// Write gating and round-robin drain arbiter for the two-FIFO buffer stage.
// Quantum-limited grant, back-pressure, pop counters and stall/error supervision.
module fifo_flow_ctrl #(
  parameter int QUANTUM   = 4,
  parameter int STALL_MAX = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             fifo0_empty,
  input  logic             fifo1_empty,
  input  logic             fifo0_almost_full,
  input  logic             fifo1_almost_full,
  input  logic             fifo0_error,
  input  logic             fifo1_error,
  input  logic             down_ready,
  output logic             write,
  output logic             read0,
  output logic             read1,
  output logic             sel,
  output logic             valid,
  output logic             pause,
  output logic             idle,
  output logic             active,
  output logic             error,
  output logic [CNT_W-1:0] pop_cnt0,
  output logic [CNT_W-1:0] pop_cnt1
);

  localparam int QW = $clog2(QUANTUM + 1);
  localparam int SW = $clog2(STALL_MAX + 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_INIT,
    S_IDLE,
    S_ACTIVE,
    S_ERROR
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic             r_g;
  logic [QW-1:0]    r_q;
  logic [SW-1:0]    r_s;
  logic             r_sel;
  logic             r_valid;
  logic             r_pause;
  logic             r_error;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic w_st_idle;
  logic w_st_act;
  logic w_st_err;
  logic w_both_e;
  logic w_e_g;
  logic w_e_o;
  logic w_pop_g;
  logic w_pop_o;
  logic w_pop;
  logic w_pop_idx;
  logic w_stall;
  logic w_err;
  logic w_q_last;
  logic w_write;
  logic w_pause_d;

  assign w_st_idle = (r_state == S_IDLE);
  assign w_st_act  = (r_state == S_ACTIVE);
  assign w_st_err  = (r_state == S_ERROR);
  assign w_both_e  = fifo0_empty & fifo1_empty;
  assign w_e_g     = r_g ? fifo1_empty : fifo0_empty;
  assign w_e_o     = r_g ? fifo0_empty : fifo1_empty;

  assign w_pop_g   = w_st_act & down_ready & ~w_e_g;
  assign w_pop_o   = w_st_act & down_ready & w_e_g & ~w_e_o;
  assign w_pop     = w_pop_g | w_pop_o;
  assign w_pop_idx = r_g ^ w_pop_o;
  assign w_q_last  = (r_q >= QW'(QUANTUM - 1));

  // Error fires on the edge where the stall count would reach STALL_MAX.
  assign w_stall = w_st_act & ~down_ready & ~w_both_e;
  assign w_err   = (r_state != S_RESET) &
                   (fifo0_error | fifo1_error |
                    (w_stall & (r_s == SW'(STALL_MAX - 1))));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RESET;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (w_err) begin
      w_nxt = S_ERROR;
    end else begin
      unique case (r_state)
        S_RESET:  w_nxt = S_INIT;
        S_INIT:   if (init) w_nxt = S_IDLE;
        S_IDLE:   if (!w_both_e) w_nxt = S_ACTIVE;
        S_ACTIVE: if (w_both_e && !w_pop) w_nxt = S_IDLE;
        S_ERROR:  if (init) w_nxt = S_IDLE;
        default:  w_nxt = S_RESET;
      endcase
    end
  end

  always_comb begin
    w_write   = 1'b0;
    w_pause_d = 1'b0;
    unique case (1'b1)
      w_st_idle | w_st_act: begin
        w_write   = ~(fifo0_almost_full | fifo1_almost_full);
        w_pause_d = fifo0_almost_full | fifo1_almost_full;
      end
      w_st_err: w_pause_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_g     <= 1'b0;
      r_q     <= '0;
      r_s     <= '0;
      r_sel   <= 1'b0;
      r_valid <= 1'b0;
      r_pause <= 1'b0;
      r_error <= 1'b0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      r_pause <= w_pause_d;
      r_error <= (w_nxt == S_ERROR);
      r_valid <= w_pop;
      if (w_pop) r_sel <= w_pop_idx;
      if (w_pop && !w_pop_idx) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (w_pop && w_pop_idx)  r_cnt1 <= r_cnt1 + CNT_W'(1);

      if (!(w_st_act && w_nxt == S_ACTIVE) || w_pop) r_s <= '0;
      else if (w_stall && r_s < SW'(STALL_MAX)) r_s <= r_s + SW'(1);

      if (w_st_err && w_nxt == S_IDLE) begin
        r_g <= 1'b0;
        r_q <= '0;
      end else if (w_pop_o) begin
        r_g <= ~r_g;
        r_q <= QW'(1);
      end else if (w_pop_g) begin
        if (w_q_last) begin
          r_q <= '0;
          if (!w_e_o) r_g <= ~r_g;
        end else begin
          r_q <= r_q + QW'(1);
        end
      end else if (w_st_act && w_e_g) begin
        r_g <= ~r_g;
        r_q <= '0;
      end
    end
  end

  assign write    = w_write;
  assign read0    = w_pop & ~w_pop_idx;
  assign read1    = w_pop & w_pop_idx;
  assign sel      = r_sel;
  assign valid    = r_valid;
  assign pause    = r_pause;
  assign idle     = w_st_idle;
  assign active   = w_st_act;
  assign error    = r_error;
  assign pop_cnt0 = r_cnt0;
  assign pop_cnt1 = r_cnt1;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Bench for fifo_flow_ctrl: FIFO occupancy model, pop-order scoreboard,
// IDLE/ERROR vector table and hand-written drain/stall/reset sequences.
module tb_fifo_flow_ctrl;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic init = 1'b0;
  logic af0 = 1'b0;
  logic af1 = 1'b0;
  logic er0 = 1'b0;
  logic er1 = 1'b0;
  logic down_ready = 1'b1;
  logic fifo0_empty;
  logic fifo1_empty;
  logic write;
  logic read0;
  logic read1;
  logic sel;
  logic valid;
  logic pause;
  logic idle;
  logic active;
  logic error;
  logic [CNT_W-1:0] pop_cnt0;
  logic [CNT_W-1:0] pop_cnt1;

  int cnt0 = 0;
  int cnt1 = 0;
  int add0 = 0;
  int add1 = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit sb_en = 1'b0;
  bit exp_sel;
  bit exp_q[$];

  fifo_flow_ctrl #(
    .QUANTUM(4),
    .STALL_MAX(16),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .init(init),
    .fifo0_empty(fifo0_empty),
    .fifo1_empty(fifo1_empty),
    .fifo0_almost_full(af0),
    .fifo1_almost_full(af1),
    .fifo0_error(er0),
    .fifo1_error(er1),
    .down_ready(down_ready),
    .write(write),
    .read0(read0),
    .read1(read1),
    .sel(sel),
    .valid(valid),
    .pause(pause),
    .idle(idle),
    .active(active),
    .error(error),
    .pop_cnt0(pop_cnt0),
    .pop_cnt1(pop_cnt1)
  );

  always #5 clk = ~clk;

  assign fifo0_empty = (cnt0 == 0);
  assign fifo1_empty = (cnt1 == 0);

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (mon_en)
      chk("strobe_legal",
          int'((read0 && cnt0 == 0) || (read1 && cnt1 == 0) ||
               (read0 && read1)), 0);
    cnt0 <= cnt0 + add0 - int'(read0);
    cnt1 <= cnt1 + add1 - int'(read1);
  end

  always @(negedge clk) begin
    if (sb_en && valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 1, 0);
      end else begin
        exp_sel = exp_q.pop_front();
        chk("pop_sel", int'(sel), int'(exp_sel));
      end
    end
  end

  task automatic expect_n(input bit idx, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(idx);
  endtask

  task automatic load(input int n0, input int n1);
    add0 = n0;
    add1 = n1;
    @(negedge clk);
    add0 = 0;
    add1 = 0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    n = 0;
    while (!idle && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, int'(idle), 1);
  endtask

  // in = {init, af0, af1, er0, er1}; ex = {write, idle, error, pause}
  typedef struct packed {
    logic [4:0] in;
    logic [3:0] ex;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vcnt;
    tbl[0]  = '{5'b00000, 4'b1100};
    tbl[1]  = '{5'b10000, 4'b1100};
    tbl[2]  = '{5'b01000, 4'b0101};
    tbl[3]  = '{5'b00100, 4'b0101};
    tbl[4]  = '{5'b11100, 4'b0101};
    tbl[5]  = '{5'b00000, 4'b1100};
    tbl[6]  = '{5'b00010, 4'b1010};
    tbl[7]  = '{5'b00000, 4'b0011};
    tbl[8]  = '{5'b10001, 4'b0011};
    tbl[9]  = '{5'b10000, 4'b0101};
    tbl[10] = '{5'b10101, 4'b0011};
    tbl[11] = '{5'b10000, 4'b0101};
    tbl[12] = '{5'b00000, 4'b1100};

    // 1: reset state, then INIT, then IDLE
    repeat (2) @(negedge clk);
    chk("rst_outs", int'({write, read0, read1, sel, valid,
                          pause, idle, active, error}), 0);
    chk("rst_cnt0", int'(pop_cnt0), 0);
    chk("rst_cnt1", int'(pop_cnt1), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("init_idle", int'(idle), 0);
    chk("init_write", int'(write), 0);
    @(negedge clk);
    chk("init_hold", int'(idle), 0);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("t1_idle", int'(idle), 1);
    chk("t1_write", int'(write), 1);
    chk("t1_reads", int'({read0, read1}), 0);
    mon_en = 1'b1;
    sb_en = 1'b1;

    // vector table in IDLE/ERROR with both FIFOs empty
    for (int i = 0; i < 13; i++) begin
      {init, af0, af1, er0, er1} = tbl[i].in;
      #1;
      chk($sformatf("tbl%0d_write", i), int'(write), int'(tbl[i].ex[3]));
      @(negedge clk);
      chk($sformatf("tbl%0d_idle", i), int'(idle), int'(tbl[i].ex[2]));
      chk($sformatf("tbl%0d_error", i), int'(error), int'(tbl[i].ex[1]));
      chk($sformatf("tbl%0d_pause", i), int'(pause), int'(tbl[i].ex[0]));
    end
    {init, af0, af1, er0, er1} = 5'b00000;

    // 2: 10+10 words, quantum 4, no bubbles
    expect_n(1'b0, 4);
    expect_n(1'b1, 4);
    expect_n(1'b0, 4);
    expect_n(1'b1, 4);
    expect_n(1'b0, 2);
    expect_n(1'b1, 2);
    load(10, 10);
    @(negedge clk);
    chk("t2_active", int'(active), 1);
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    chk("t2_back_to_back", vcnt, 20);
    @(negedge clk);
    chk("t2_idle", int'(idle), 1);
    chk("t2_valid_off", int'(valid), 0);
    chk("t2_cnt0", int'(pop_cnt0), 10);
    chk("t2_cnt1", int'(pop_cnt1), 10);
    chk("t2_queue", exp_q.size(), 0);

    // 3: only FIFO1 non-empty
    expect_n(1'b1, 6);
    load(0, 6);
    wait_drain("t3", 50);
    chk("t3_cnt0", int'(pop_cnt0), 10);
    chk("t3_cnt1", int'(pop_cnt1), 16);

    // 4: almost-full during drain
    expect_n(1'b0, 8);
    load(8, 0);
    @(negedge clk);
    chk("t4_active", int'(active), 1);
    af0 = 1'b1;
    #1;
    chk("t4_write_drop", int'(write), 0);
    chk("t4_read0", int'(read0), 1);
    @(negedge clk);
    chk("t4_pause", int'(pause), 1);
    chk("t4_valid", int'(valid), 1);
    af0 = 1'b0;
    #1;
    chk("t4_write_back", int'(write), 1);
    @(negedge clk);
    chk("t4_pause_off", int'(pause), 0);
    wait_drain("t4", 50);
    chk("t4_cnt0", int'(pop_cnt0), 18);

    // 5: 16 stalled cycles raise error, init recovers
    down_ready = 1'b0;
    load(3, 0);
    @(negedge clk);
    chk("t5_active", int'(active), 1);
    repeat (15) @(negedge clk);
    chk("t5_no_err_15", int'(error), 0);
    chk("t5_still_active", int'(active), 1);
    @(negedge clk);
    chk("t5_error", int'(error), 1);
    chk("t5_left_active", int'(active), 0);
    chk("t5_write", int'(write), 0);
    down_ready = 1'b1;
    #1;
    chk("t5_no_reads", int'({read0, read1}), 0);
    @(negedge clk);
    chk("t5_pause", int'(pause), 1);
    chk("t5_no_valid", int'(valid), 0);
    chk("t5_cnt_hold", int'(pop_cnt0), 18);
    expect_n(1'b0, 3);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("t5_idle", int'(idle), 1);
    chk("t5_err_clr", int'(error), 0);
    wait_drain("t5", 50);
    chk("t5_cnt0", int'(pop_cnt0), 21);

    // 6: counter wrap, then async reset mid-burst
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("t6_cnt0_zero", int'(pop_cnt0), 0);
    expect_n(1'b0, 300);
    load(300, 0);
    wait_drain("t6", 400);
    chk("t6_wrap", int'(pop_cnt0), 44);
    chk("t6_cnt1", int'(pop_cnt1), 0);
    sb_en = 1'b0;
    load(50, 0);
    repeat (5) @(negedge clk);
    chk("t6_burst", int'(read0), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_outs", int'({write, read0, read1, sel, valid,
                               pause, idle, active, error}), 0);
    chk("t6_async_cnt0", int'(pop_cnt0), 0);
    chk("t6_async_cnt1", int'(pop_cnt1), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_init_state", int'({idle, write}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
